branch_predictor: RTL and testbench



---
 rtl/branch_predictor_if.sv | 21 ++
 rtl/branch_predictor.sv | 71 +++++++
 tb/tb_branch_predictor.sv | 107 ++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup, EX/MEM training and tracker bus of the branch predictor
interface branch_predictor_if;
    typedef logic [31:0] word_t;
    word_t if_pc;
    logic  pred_taken;
    word_t pred_npc;
    logic  upd_en;
    word_t upd_pc;
    logic  upd_taken;
    word_t upd_target;
    logic  upd_pred_taken;
    word_t mispred_cnt;
    modport master (
        output if_pc, upd_en, upd_pc, upd_taken, upd_target, upd_pred_taken,
        input  pred_taken, pred_npc, mispred_cnt
    );
    modport slave (
        input  if_pc, upd_en, upd_pc, upd_taken, upd_target, upd_pred_taken,
        output pred_taken, pred_npc, mispred_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit direction counters and a saturating mispredict count
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input logic               CLK,
    input logic               RST,
    branch_predictor_if.slave bus
);
    localparam int TAG_W = 30 - IDX_W;
    typedef enum logic [1:0] {NS = 2'b00, NH = 2'b01, TH = 2'b10, TS = 2'b11} bpred_t;
    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];
    bpred_t            state_q  [ENTRIES];
    logic [31:0]       cnt_q;
    logic [IDX_W-1:0]  rd_idx;
    logic [TAG_W-1:0]  rd_tag;
    logic              rd_hit;
    logic [IDX_W-1:0]  wr_idx;
    logic [TAG_W-1:0]  wr_tag;
    logic              wr_hit;
    bpred_t            wr_state;
    bpred_t            nxt_state;
    logic [31:0]       nxt_target;
    logic              unused_pc_lsb;
    assign unused_pc_lsb = ^{bus.if_pc[1:0], bus.upd_pc[1:0]};
    assign rd_idx = bus.if_pc[IDX_W+1:2];
    assign rd_tag = bus.if_pc[31:IDX_W+2];
    assign wr_idx = bus.upd_pc[IDX_W+1:2];
    assign wr_tag = bus.upd_pc[31:IDX_W+2];
    // Lookup reads the registered table only, so a same-cycle update is not bypassed
    always_comb begin
        rd_hit         = valid_q[rd_idx] && tag_q[rd_idx] == rd_tag;
        bus.pred_taken = rd_hit && state_q[rd_idx][1];
        bus.pred_npc   = bus.pred_taken ? target_q[rd_idx] : bus.if_pc + 32'd4;
    end
    // Next entry contents: step the counter on a hit, allocate weak state on a miss
    always_comb begin
        wr_hit     = valid_q[wr_idx] && tag_q[wr_idx] == wr_tag;
        wr_state   = state_q[wr_idx];
        nxt_state  = !wr_hit ? (bus.upd_taken ? TH : NH) :
                     bus.upd_taken ? (wr_state == NS ? NH : wr_state == NH ? TH : TS) :
                                     (wr_state == TS ? TH : wr_state == TH ? NH : NS);
        nxt_target = (!wr_hit || bus.upd_taken) ? bus.upd_target : target_q[wr_idx];
    end
    for (genvar e = 0; e < ENTRIES; e++) begin : g_ent
        // Entry e is cleared by reset and rewritten by any update that indexes it
        always_ff @(posedge CLK) begin
            if (RST) begin
                valid_q[e]  <= 1'b0;
                tag_q[e]    <= '0;
                target_q[e] <= '0;
                state_q[e]  <= NH;
            end else if (bus.upd_en && wr_idx == IDX_W'(e)) begin
                valid_q[e]  <= 1'b1;
                tag_q[e]    <= wr_tag;
                target_q[e] <= nxt_target;
                state_q[e]  <= nxt_state;
            end
        end
    end
    // Mispredict count sticks at all-ones instead of wrapping
    always_ff @(posedge CLK) begin
        if (RST)
            cnt_q <= '0;
        else if (bus.upd_en && bus.upd_taken != bus.upd_pred_taken && cnt_q != '1)
            cnt_q <= cnt_q + 32'd1;
    end
    assign bus.mispred_cnt = cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed checks of lookup, training, aliasing, reset and counter saturation
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    branch_predictor_if bus();
    branch_predictor dut (.CLK(clk), .RST(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic look(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] npc);
        bus.if_pc = pc;
        #1;
        chk({tag, "_taken"}, 32'(bus.pred_taken), 32'(tk));
        chk({tag, "_npc"}, bus.pred_npc, npc);
    endtask
    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg, input logic pt);
        bus.upd_en = 1'b1;
        bus.upd_pc = pc;
        bus.upd_taken = tk;
        bus.upd_target = tg;
        bus.upd_pred_taken = pt;
        @(negedge clk);
        bus.upd_en = 1'b0;
    endtask
    initial begin
        rst = 1'b1;
        bus.if_pc = 32'h40;
        bus.upd_en = 1'b0;
        bus.upd_pc = '0;
        bus.upd_taken = 1'b0;
        bus.upd_target = '0;
        bus.upd_pred_taken = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        look("rst", 32'h40, 1'b0, 32'h44);
        chk("rst_cnt", bus.mispred_cnt, 32'd0);
        upd(32'h40, 1'b1, 32'h80, 1'b0);
        look("alloc", 32'h40, 1'b1, 32'h80);
        chk("alloc_cnt", bus.mispred_cnt, 32'd1);
        chk("alloc_st", 32'(dut.state_q[0]), 32'd2);
        upd(32'h40, 1'b1, 32'h80, 1'b1);
        chk("st_ts", 32'(dut.state_q[0]), 32'd3);
        upd(32'h40, 1'b0, 32'h0, 1'b1);
        chk("st_th", 32'(dut.state_q[0]), 32'd2);
        look("th", 32'h40, 1'b1, 32'h80);
        upd(32'h40, 1'b0, 32'h0, 1'b1);
        chk("st_nh", 32'(dut.state_q[0]), 32'd1);
        upd(32'h40, 1'b0, 32'h0, 1'b0);
        chk("st_ns", 32'(dut.state_q[0]), 32'd0);
        look("ns", 32'h40, 1'b0, 32'h44);
        chk("ns_cnt", bus.mispred_cnt, 32'd3);
        bus.upd_pc = 32'h40;
        bus.upd_taken = 1'b1;
        bus.upd_pred_taken = 1'b0;
        @(negedge clk);
        chk("hold_cnt", bus.mispred_cnt, 32'd3);
        chk("hold_st", 32'(dut.state_q[0]), 32'd0);
        upd(32'h40, 1'b1, 32'h80, 1'b0);
        upd(32'h40, 1'b1, 32'h80, 1'b0);
        look("train", 32'h40, 1'b1, 32'h80);
        upd(32'h80, 1'b0, 32'h100, 1'b0);
        look("alias40", 32'h40, 1'b0, 32'h44);
        look("alias80", 32'h80, 1'b0, 32'h84);
        chk("alias_st", 32'(dut.state_q[0]), 32'd1);
        chk("alias_cnt", bus.mispred_cnt, 32'd5);
        bus.if_pc = 32'h40;
        bus.upd_en = 1'b1;
        bus.upd_pc = 32'h40;
        bus.upd_taken = 1'b1;
        bus.upd_target = 32'h200;
        bus.upd_pred_taken = 1'b0;
        #1;
        chk("coll_same", 32'(bus.pred_taken), 32'd0);
        @(negedge clk);
        bus.upd_en = 1'b0;
        look("coll_next", 32'h40, 1'b1, 32'h200);
        upd(32'h44, 1'b1, 32'h300, 1'b0);
        look("tr44", 32'h44, 1'b1, 32'h300);
        rst = 1'b1;
        upd(32'h40, 1'b1, 32'h200, 1'b0);
        rst = 1'b0;
        look("mid40", 32'h40, 1'b0, 32'h44);
        look("mid44", 32'h44, 1'b0, 32'h48);
        chk("mid_cnt", bus.mispred_cnt, 32'd0);
        chk("mid_st", 32'(dut.state_q[0]), 32'd1);
        look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
        force dut.cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut.cnt_q;
        upd(32'h40, 1'b1, 32'h80, 1'b0);
        chk("sat1", bus.mispred_cnt, 32'hFFFF_FFFE);
        upd(32'h40, 1'b0, 32'h80, 1'b1);
        chk("sat2", bus.mispred_cnt, 32'hFFFF_FFFF);
        upd(32'h40, 1'b1, 32'h80, 1'b0);
        chk("sat3", bus.mispred_cnt, 32'hFFFF_FFFF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
